hex8_scan: RTL and testbench



---
 rtl/hex8_pkg.sv | 24 ++
 rtl/hex8_scan_hex_to_seg.sv | 16 +
 rtl/hex8_scan.sv | 128 ++++++++++++
 tb/tb_hex8_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hex8_pkg.sv
// Shared constants and types for the hex8_scan seven-segment scan controller.
// Segment codes are active-low with bit 7 = dp and bits 6..0 = g..a.
package hex8_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_NONE  = 8'h00;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
  } seg_word_t;

  localparam seg_word_t WORD_IDLE = '{sel: SEL_NONE, seg: SEG_BLANK};

  function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/hex8_scan_hex_to_seg.sv
// Combinational nibble to active-low seven-segment lookup (dp bit not handled here).
module hex_to_seg
  import hex8_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = HEX_SEG[nibble];
    seg  = code[6:0];
  end

endmodule

// File: rtl/hex8_scan.sv
// Eight-digit time-multiplexed seven-segment scan controller feeding a 74HC595 chain.
// Optional decimal-point input is enabled with the HEX8_SCAN_DP_EN macro.
module hex8_scan
  import hex8_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Disp_data,
  input  logic [7:0]  Disp_en,
`ifdef HEX8_SCAN_DP_EN
  input  logic [7:0]  Dp,
`endif
  output logic [15:0] Data_out,
  output logic        Load
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       digit_idx;

  logic [31:0]      data_p0;
  logic [7:0]       en_p0;
  logic [2:0]       idx_p0;
  logic             vld_p0;

  logic [3:0]       nibble_p0;
  logic [6:0]       code_p0;
  logic             dp_lit_p0;
  seg_word_t        word_nxt;

  seg_word_t        word_p1;
  logic             vld_p1;

  // Digit enable and dp decide whether the slot lights up; a blanked digit ignores dp.
  function automatic seg_word_t encode_word(
    input logic       en,
    input logic       dp_lit,
    input logic [2:0] idx,
    input logic [6:0] code
  );
    seg_word_t w;
    if (en) begin
      w.sel = sel_onehot(idx);
      w.seg = {~dp_lit, code};
    end else begin
      w = WORD_IDLE;
    end
    return w;
  endfunction

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        digit_idx <= digit_idx + 3'd1;
    end
  end

  // Stage p0: frame snapshot on the digit-0 tick, slot index capture
`ifdef HEX8_SCAN_DP_EN
  logic [7:0] dp_p0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_p0 <= '0;
      en_p0   <= '0;
`ifdef HEX8_SCAN_DP_EN
      dp_p0   <= '0;
`endif
      idx_p0  <= 3'd0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (tick) begin
        idx_p0 <= digit_idx;
        if (digit_idx == 3'd0) begin
          data_p0 <= Disp_data;
          en_p0   <= Disp_en;
`ifdef HEX8_SCAN_DP_EN
          dp_p0   <= Dp;
`endif
        end
      end
    end
  end

  assign nibble_p0 = data_p0[{idx_p0, 2'b00} +: 4];

`ifdef HEX8_SCAN_DP_EN
  assign dp_lit_p0 = dp_p0[idx_p0];
`else
  assign dp_lit_p0 = 1'b0;
`endif

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_p0),
    .seg    (code_p0)
  );

  assign word_nxt = encode_word(en_p0[idx_p0], dp_lit_p0, idx_p0, code_p0);

  // Stage p1: registered output word and one-cycle load strobe
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      word_p1 <= WORD_IDLE;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0)
        word_p1 <= word_nxt;
    end
  end

  assign Data_out = word_p1;
  assign Load     = vld_p1;

endmodule

// File: tb/tb_hex8_scan.sv
// Scoreboard bench for hex8_scan with SCAN_DIV = 4.
module tb_hex8_scan;

  localparam int SCAN_DIV = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] Disp_data = 32'h0;
  logic [7:0]  Disp_en = 8'h0;
`ifdef HEX8_SCAN_DP_EN
  logic [7:0]  Dp = 8'h00;
`endif
  logic [15:0] Data_out;
  logic        Load;

  always #5 Clk = ~Clk;

  hex8_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Disp_data (Disp_data),
    .Disp_en   (Disp_en),
`ifdef HEX8_SCAN_DP_EN
    .Dp        (Dp),
`endif
    .Data_out  (Data_out),
    .Load      (Load)
  );

  int n_checks = 0;
  int n_fail = 0;
  int load_cnt = 0;
  int edge_cnt = 0;
  int last_edge = 0;
  bit first_load = 1'b1;
  logic [15:0] cur_word = 16'h00FF;
  logic [15:0] exp_q[$];

  logic [15:0] frame_a [8] = '{16'h01C0, 16'h02F9, 16'h04A4, 16'h08B0,
                               16'h1099, 16'h2092, 16'h4082, 16'h80F8};
  logic [15:0] frame_m [8] = '{16'h0180, 16'h00FF, 16'h0488, 16'h00FF,
                               16'h00FF, 16'h20A1, 16'h00FF, 16'h808E};
  logic [15:0] frame_1 [8] = '{16'h01F9, 16'h02F9, 16'h04F9, 16'h08F9,
                               16'h10F9, 16'h20F9, 16'h40F9, 16'h80F9};

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Monitor: pops one expected word per Load, checks spacing and hold stability
  always @(negedge Clk) begin
    if (!Reset_n) begin
      cur_word   = 16'h00FF;
      first_load = 1'b1;
    end else if (Load === 1'b1) begin
      load_cnt++;
      if (first_load)
        check_int("first_load_cycle", edge_cnt, SCAN_DIV + 1);
      else
        check_int("load_spacing", edge_cnt - last_edge, SCAN_DIV);
      first_load = 1'b0;
      last_edge  = edge_cnt;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_load: got %h, expected no load", Data_out);
      end else begin
        check16("load_word", Data_out, exp_q.pop_front());
      end
      cur_word = Data_out;
    end else begin
      check16("hold_word", Data_out, cur_word);
    end
  end

  task automatic wait_loads(input int n);
    int guard = 0;
    while (load_cnt < n && guard < 400) begin
      @(posedge Clk);
      guard++;
    end
    if (load_cnt < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_loads_timeout: got %0d loads, expected %0d", load_cnt, n);
    end
  endtask

  initial begin
    Disp_data = 32'h76543210;
    Disp_en   = 8'hFF;
    Reset_n   = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check16("reset_data_out", Data_out, 16'h00FF);
    check_int("reset_load", int'(Load), 0);

    for (int i = 0; i < 8; i++) exp_q.push_back(frame_a[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(frame_a[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(frame_m[i]);
    for (int i = 0; i < 6; i++) exp_q.push_back(frame_1[i]);

    @(negedge Clk);
    Reset_n = 1'b1;

    // Frame 2 snapshot already taken once its digit-0 word is out
    wait_loads(9);
    Disp_data = 32'hFEDCBA98;
    Disp_en   = 8'b1010_0101;

    // Digit 3 of the masked frame is on display: change must wait for next frame
    wait_loads(20);
    Disp_data = 32'h11111111;
    Disp_en   = 8'hFF;

    // Digit 5 of the all-ones frame: asynchronous reset mid-slot
    wait_loads(30);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check16("midframe_reset_data_out", Data_out, 16'h00FF);
    check_int("midframe_reset_load", int'(Load), 0);
    check_int("queue_drained_before_reset", exp_q.size(), 0);

    Disp_data = 32'h76543210;
    repeat (3) @(posedge Clk);
    for (int i = 0; i < 8; i++) exp_q.push_back(frame_a[i]);
    @(negedge Clk);
    Reset_n = 1'b1;

    wait_loads(38);
    repeat (2) @(posedge Clk);
    check_int("queue_drained_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
